// File: rtl/debug_ctrl_unit_if.sv
// rtl/debug_ctrl_unit_if.sv - board-control and CPU-debug signal bundle for debug_ctrl_unit
interface debug_ctrl_unit_if #(
    parameter int DATA_W = 32,
    parameter int NSTAT  = 7,
    parameter int SEL_W  = 3,
    parameter int ADDR_W = 8
);
    logic                    succ;
    logic                    step;
    logic                    burst;
    logic                    inc;
    logic                    dec;
    logic                    m_rf;
    logic [SEL_W-1:0]        sel;
    logic [NSTAT*DATA_W-1:0] status;
    logic [DATA_W-1:0]       m_data;
    logic [DATA_W-1:0]       rf_data;
    logic [DATA_W-1:0]       pc;
    logic [DATA_W-1:0]       bp_addr;
    logic                    bp_en;
    logic                    run;
    logic                    halted;
    logic [ADDR_W-1:0]       m_rf_addr;
    logic [DATA_W-1:0]       data_display;

    modport master (
        output succ, step, burst, inc, dec, m_rf, sel, status,
               m_data, rf_data, pc, bp_addr, bp_en,
        input  run, halted, m_rf_addr, data_display
    );

    modport slave (
        input  succ, step, burst, inc, dec, m_rf, sel, status,
               m_data, rf_data, pc, bp_addr, bp_en,
        output run, halted, m_rf_addr, data_display
    );
endinterface

// File: rtl/debug_ctrl_unit.sv
// rtl/debug_ctrl_unit.sv - button conditioning, CPU run control, browse address and display mux
// Optional breakpoint/HALT support is compiled in when BREAKPOINT_EN is defined.
module debug_ctrl_unit #(
    parameter int DATA_W    = 32,
    parameter int NSTAT     = 7,
    parameter int SEL_W     = 3,
    parameter int ADDR_W    = 8,
    parameter int DEB_CYC   = 16,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    debug_ctrl_unit_if.slave  io_dbg
);

    localparam int DCW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_BURST,
        S_HALT
    } state_t;

    // Bit 0 = step, bit 1 = inc, bit 2 = dec
    logic [2:0]     w_raw;
    logic [2:0]     r_sync1;
    logic [2:0]     r_sync2;
    logic [2:0]     r_lvl;
    logic [2:0]     r_lvl_d;
    logic [DCW-1:0] r_deb [3];
    logic [2:0]     w_pulse;

    assign w_raw   = {io_dbg.dec, io_dbg.inc, io_dbg.step};
    assign w_pulse = r_lvl & ~r_lvl_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl   <= '0;
            r_lvl_d <= '0;
            for (int i = 0; i < 3; i++) begin
                r_deb[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_lvl_d <= r_lvl;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_lvl[i]) begin
                    if (r_deb[i] == DCW'(DEB_CYC - 1)) begin
                        r_lvl[i] <= r_sync2[i];
                        r_deb[i] <= '0;
                    end else begin
                        r_deb[i] <= r_deb[i] + DCW'(1);
                    end
                end else begin
                    r_deb[i] <= '0;
                end
            end
        end
    end

    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (w_pulse[1] && !w_pulse[2]) begin
            r_addr <= r_addr + ADDR_W'(1);
        end else if (w_pulse[2] && !w_pulse[1]) begin
            r_addr <= r_addr - ADDR_W'(1);
        end
    end

    assign io_dbg.m_rf_addr = r_addr;

    logic w_bp_hit;

`ifdef BREAKPOINT_EN
    assign w_bp_hit = io_dbg.bp_en && (io_dbg.pc == io_dbg.bp_addr);
`else
    logic w_unused_bp;
    assign w_unused_bp = ^{io_dbg.pc, io_dbg.bp_addr, io_dbg.bp_en};
    assign w_bp_hit    = 1'b0;
`endif

    state_t         r_state;
    state_t         w_state_next;
    logic [BCW-1:0] r_cnt;
    logic [BCW-1:0] w_cnt_next;
    logic           r_run;
    logic           w_run_next;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (io_dbg.succ) begin
                    w_state_next = S_RUN;
                end else if (w_pulse[0]) begin
                    if (io_dbg.burst) begin
                        w_state_next = S_BURST;
                        w_cnt_next   = BCW'(BURST_LEN - 1);
                    end else begin
                        w_state_next = S_STEP;
                    end
                end
            end
            S_RUN: begin
                if (w_bp_hit) begin
                    w_state_next = S_HALT;
                end else if (!io_dbg.succ) begin
                    w_state_next = S_IDLE;
                end
            end
            S_STEP: begin
                w_state_next = S_IDLE;
            end
            S_BURST: begin
                if (w_bp_hit) begin
                    w_state_next = S_HALT;
                end else if (io_dbg.succ) begin
                    w_state_next = S_RUN;
                end else if (r_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - BCW'(1);
                end
            end
            // STEP ignores the breakpoint, so a step press walks off the halt address
            S_HALT: begin
                if (!io_dbg.succ) begin
                    w_state_next = S_IDLE;
                end else if (w_pulse[0]) begin
                    w_state_next = S_STEP;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_run_next = (w_state_next == S_RUN) || (w_state_next == S_STEP) ||
                        (w_state_next == S_BURST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_run   <= w_run_next;
        end
    end

    assign io_dbg.run = r_run;

`ifdef BREAKPOINT_EN
    logic r_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= (w_state_next == S_HALT);
        end
    end

    assign io_dbg.halted = r_halted;
`else
    assign io_dbg.halted = 1'b0;
`endif

    logic [DATA_W-1:0] w_disp;
    logic [DATA_W-1:0] r_disp;

    always_comb begin
        w_disp = '0;
        if (io_dbg.sel == '0) begin
            w_disp = io_dbg.m_rf ? io_dbg.m_data : io_dbg.rf_data;
        end else begin
            for (int i = 0; i < NSTAT; i++) begin
                if (io_dbg.sel == SEL_W'(i + 1)) begin
                    w_disp = io_dbg.status[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp <= '0;
        end else begin
            r_disp <= w_disp;
        end
    end

    assign io_dbg.data_display = r_disp;

endmodule

// File: tb/tb_debug_ctrl_unit.sv
// tb/tb_debug_ctrl_unit.sv - self-checking bench for debug_ctrl_unit against a behavioural model
module tb_debug_ctrl_unit;

    localparam int DATA_W    = 32;
    localparam int NSTAT     = 7;
    localparam int SEL_W     = 3;
    localparam int ADDR_W    = 8;
    localparam int DEB_CYC   = 4;
    localparam int BURST_LEN = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    debug_ctrl_unit_if #(.DATA_W(DATA_W), .NSTAT(NSTAT), .SEL_W(SEL_W), .ADDR_W(ADDR_W)) bus ();

    debug_ctrl_unit #(
        .DATA_W(DATA_W), .NSTAT(NSTAT), .SEL_W(SEL_W), .ADDR_W(ADDR_W),
        .DEB_CYC(DEB_CYC), .BURST_LEN(BURST_LEN)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_dbg (bus)
    );

    logic [DATA_W-1:0] words [NSTAT];

    always_comb begin
        for (int i = 0; i < NSTAT; i++) begin
            bus.status[i*DATA_W +: DATA_W] = words[i];
        end
    end

    int n_chk   = 0;
    int n_err   = 0;
    int cyc_no  = 0;
    int run_cnt = 0;
    int rise_at = -1;
    int t0      = 0;
    bit prev_run = 1'b0;

    // Model: per-button sync stages, accepted level, previous accepted level, disagreement streak
    bit s1 [3];
    bit s2 [3];
    bit acc [3];
    bit accp [3];
    int streak [3];
    // Model: continuous run, halted, owed run cycles from a step/burst press
    bit m_cont;
    bit m_halt;
    bit m_burst;
    int m_left;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_disp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc_no);
        end
    endtask

    function automatic bit raw_of(input int b);
        case (b)
            0:       return bus.step;
            1:       return bus.inc;
            default: return bus.dec;
        endcase
    endfunction

    task automatic mdl_reset();
        for (int b = 0; b < 3; b++) begin
            s1[b] = 0; s2[b] = 0; acc[b] = 0; accp[b] = 0; streak[b] = 0;
        end
        m_cont = 0; m_halt = 0; m_burst = 0; m_left = 0;
        m_addr = '0; m_disp = '0;
    endtask

    task automatic mdl_step();
        bit p [3];
        bit bp;
        int s;
        logic [DATA_W-1:0] d;
        for (int b = 0; b < 3; b++) p[b] = acc[b] && !accp[b];
        s = int'(bus.sel);
        if (s == 0) d = bus.m_rf ? bus.m_data : bus.rf_data;
        else if (s <= NSTAT) d = words[s-1];
        else d = '0;
`ifdef BREAKPOINT_EN
        bp = bus.bp_en && (bus.pc == bus.bp_addr);
`else
        bp = 0;
`endif
        if (m_cont) begin
            if (bp) begin m_cont = 0; m_halt = 1; end
            else if (!bus.succ) m_cont = 0;
        end else if (m_left > 0) begin
            if (m_burst && bp) begin m_left = 0; m_halt = 1; end
            else if (m_burst && bus.succ) begin m_left = 0; m_cont = 1; end
            else m_left--;
        end else if (m_halt) begin
            if (!bus.succ) m_halt = 0;
            else if (p[0]) begin m_halt = 0; m_left = 1; m_burst = 0; end
        end else begin
            if (bus.succ) m_cont = 1;
            else if (p[0]) begin m_left = bus.burst ? BURST_LEN : 1; m_burst = bus.burst; end
        end
        if (p[1] && !p[2]) m_addr = m_addr + 8'd1;
        else if (p[2] && !p[1]) m_addr = m_addr - 8'd1;
        for (int b = 0; b < 3; b++) begin
            accp[b] = acc[b];
            if (s2[b] != acc[b]) begin
                streak[b]++;
                if (streak[b] == DEB_CYC) begin acc[b] = s2[b]; streak[b] = 0; end
            end else begin
                streak[b] = 0;
            end
            s2[b] = s1[b];
            s1[b] = raw_of(b);
        end
        m_disp = d;
    endtask

    task automatic cmp_all();
        chk("run", 32'(bus.run), 32'(m_cont || (m_left > 0)));
        chk("halted", 32'(bus.halted), 32'(m_halt));
        chk("addr", 32'(bus.m_rf_addr), 32'(m_addr));
        chk("disp", bus.data_display, m_disp);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) mdl_reset();
        else mdl_step();
        #1;
        cmp_all();
        cyc_no++;
        if (bus.run) run_cnt++;
        if (bus.run && !prev_run) rise_at = cyc_no;
        prev_run = bus.run;
    endtask

    task automatic set_raw(input logic [2:0] mask);
        bus.step = mask[0];
        bus.inc  = mask[1];
        bus.dec  = mask[2];
    endtask

    task automatic press(input logic [2:0] mask);
        set_raw(mask);
        repeat (8) cyc();
        set_raw(3'b000);
        repeat (8) cyc();
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        mdl_reset();
        cmp_all();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        set_raw(3'b000);
        bus.succ = 0; bus.burst = 0; bus.m_rf = 0; bus.sel = '0;
        bus.m_data = '0; bus.rf_data = '0; bus.pc = '0; bus.bp_addr = '0; bus.bp_en = 0;
        for (int i = 0; i < NSTAT; i++) words[i] = '0;
        mdl_reset();
        repeat (2) cyc();
        chk("rst_run", 32'(bus.run), 32'd0);
        chk("rst_disp", bus.data_display, 32'd0);
        rst = 1'b0;
        repeat (2) cyc();

        // Display mux
        for (int i = 0; i < NSTAT; i++) words[i] = 32'h1000_0000 + 32'(i);
        bus.sel = 3'd3;
        cyc();
        chk("sel3", bus.data_display, 32'h1000_0002);
        bus.sel = 3'd7;
        cyc();
        chk("sel7", bus.data_display, 32'h1000_0006);
        bus.sel = 3'd0; bus.m_rf = 1; bus.m_data = 32'hDEAD_BEEF;
        cyc();
        chk("sel0_m", bus.data_display, 32'hDEAD_BEEF);
        bus.m_rf = 0; bus.rf_data = 32'h1234_5678;
        cyc();
        chk("sel0_rf", bus.data_display, 32'h1234_5678);

        // Address wrap and simultaneous inc/dec
        press(3'b100);
        chk("addr_wrap_dn", 32'(bus.m_rf_addr), 32'd255);
        press(3'b010);
        press(3'b010);
        chk("addr_wrap_up", 32'(bus.m_rf_addr), 32'd1);
        press(3'b110);
        chk("addr_both", 32'(bus.m_rf_addr), 32'd1);

        // Single step latency; the press is first sampled one edge after it is applied
        t0 = cyc_no; rise_at = -1; run_cnt = 0;
        press(3'b001);
        chk("step_lat", 32'(rise_at - t0), 32'(1 + 2 + DEB_CYC));
        chk("step_len", 32'(run_cnt), 32'd1);
        run_cnt = 0;
        set_raw(3'b001);
        repeat (2) cyc();
        set_raw(3'b000);
        repeat (12) cyc();
        chk("glitch", 32'(run_cnt), 32'd0);

        // Burst, then a bounced re-press during the burst
        bus.burst = 1; run_cnt = 0;
        press(3'b001);
        chk("burst_len", 32'(run_cnt), 32'(BURST_LEN));
        run_cnt = 0;
        set_raw(3'b001); repeat (6) cyc();
        set_raw(3'b000); repeat (2) cyc();
        set_raw(3'b001); repeat (6) cyc();
        set_raw(3'b000); repeat (12) cyc();
        chk("burst_repress", 32'(run_cnt), 32'(BURST_LEN));

        // Asynchronous reset in the middle of a burst
        set_raw(3'b001);
        repeat (8) cyc();
        chk("pre_rst_run", 32'(bus.run), 32'd1);
        async_reset();
        chk("rst_mid_run", 32'(bus.run), 32'd0);
        chk("rst_mid_addr", 32'(bus.m_rf_addr), 32'd0);
        set_raw(3'b000);
        repeat (10) cyc();

        // Breakpoint
        bus.burst = 0; bus.bp_en = 1; bus.bp_addr = 32'h0000_000C; bus.pc = 32'h0; bus.succ = 1;
        cyc();
        bus.pc = 32'h4; cyc();
        bus.pc = 32'h8; cyc();
        bus.pc = 32'hC; cyc();
`ifdef BREAKPOINT_EN
        chk("bp_run", 32'(bus.run), 32'd0);
        chk("bp_halted", 32'(bus.halted), 32'd1);
`else
        chk("bp_run", 32'(bus.run), 32'd1);
        chk("bp_halted", 32'(bus.halted), 32'd0);
`endif
        run_cnt = 0;
        press(3'b001);
`ifdef BREAKPOINT_EN
        chk("bp_step_cnt", 32'(run_cnt), 32'd2);
`else
        chk("bp_step_cnt", 32'(run_cnt), 32'd16);
`endif
        bus.succ = 0;
        cyc();
        chk("bp_leave_halt", 32'(bus.halted), 32'd0);
        chk("bp_leave_run", 32'(bus.run), 32'd0);
        bus.bp_en = 0;
        repeat (2) cyc();

        // Randomised traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) == 0) bus.step = ~bus.step;
            if ($urandom_range(0, 9) == 0) bus.inc = ~bus.inc;
            if ($urandom_range(0, 9) == 0) bus.dec = ~bus.dec;
            if ($urandom_range(0, 39) == 0) bus.succ = ~bus.succ;
            if ($urandom_range(0, 29) == 0) bus.burst = ~bus.burst;
            bus.sel     = SEL_W'($urandom_range(0, 7));
            bus.m_rf    = 1'($urandom_range(0, 1));
            bus.m_data  = $urandom;
            bus.rf_data = $urandom;
            words[$urandom_range(0, NSTAT - 1)] = $urandom;
            bus.pc = 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) bus.bp_addr = 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) bus.bp_en = ~bus.bp_en;
            if ($urandom_range(0, 299) == 0) async_reset();
            else cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
